pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch stage for the multi-cycle MIPS CPU. Holds the architectural PC, drives it to the PC+4 adder, and takes the adder result back as the sequential next PC. Runs a request/acknowledge fetch against instruction memory, latches the instruction register, and loads redirect targets (branch, jump, jr, eret, exception) when the control FSM strobes a PC write.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC value after reset.
- EXC_VECTOR, 32'h0040_0004, exception entry address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_start  in  1  control FSM requests one instruction fetch.
- pc_write  in  1  load next PC selected by pc_sel.
- pc_sel  in  3  0 pc_plus4, 1 branch_target, 2 jump, 3 reg_target, 4 epc, 5 EXC_VECTOR, 6/7 hold.
- branch_target  in  32  precomputed branch address.
- reg_target  in  32  rs value for jr/jalr.
- epc  in  32  return address for eret.
- pc_plus4  in  32  PC+4 adder result.
- imem_rdata  in  32  instruction word.
- imem_ack  in  1  instruction word valid this cycle.
- pc  out  32  current PC, drives the PC+4 adder input.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- instr  out  32  instruction register.
- instr_valid  out  1  one-cycle pulse after instr updates.
- busy  out  1  fetch in progress.
- addr_err  out  1  one-cycle pulse on misaligned redirect.

## Operation
- States: IDLE, REQ. busy = (state == REQ).
- IDLE: fetch_start=1 -> REQ. pc_write=1 -> pc loads selected source; pc_sel 6/7 leaves pc unchanged. Both high in one cycle: PC load and entry to REQ happen together; the fetch uses the new PC.
- REQ: imem_req=1, imem_addr=pc (registered, stable for the whole request). On imem_ack: instr <= imem_rdata, pc <= pc_plus4, instr_valid pulses next cycle, -> IDLE. No ack: stay in REQ indefinitely.
- In REQ, pc_write and fetch_start are ignored. The control FSM never asserts them there; the bench checks that they are ignored.
- Jump source: {pc[31:28], instr[25:0], 2'b00}, built internally from the current pc (already PC+4 after fetch) and instr.
- Misalignment: if the selected source has bits [1:0] != 0, pc loads the value with [1:0] forced to 00 and addr_err pulses for one cycle. pc_plus4 is never checked.
- All arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 through the adder and is accepted unchanged.

## Timing
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, busy=0, addr_err=0, state IDLE.
- Reset asserted mid-REQ: imem_req drops immediately (asynchronously). A late ack after reset release is ignored in IDLE.
- With fetch_start high at edge N: imem_req is high in cycle N+1.
- Zero-wait memory (ack in N+1): instr and pc update at edge N+2, and instr_valid is high during cycle N+2 only. Each wait cycle adds one cycle.
- A pc_write at edge M is visible on pc in cycle M+1. addr_err is coincident with that pc update.
- fetch_start may be reasserted in the cycle instr_valid is high, giving back-to-back fetches every 2 cycles with zero-wait memory.

## Test plan
- Reset, then fetch with ack after 0 wait cycles -> imem_addr=32'h0040_0000; instr=imem_rdata; pc=32'h0040_0004; instr_valid is a single 1-cycle pulse.
- Fetch with 3 wait cycles, while toggling pc_write and fetch_start during REQ -> imem_addr stays stable, pc is unchanged until ack, the extra requests are ignored, exactly one fetch occurs.
- pc_write with each pc_sel 0-5 and then 6/7 -> pc equals the respective source. Jump with pc=32'h9000_0010, instr[25:0]=26'h0000100 -> pc=32'h9000_0400. sel 6/7 -> pc held.
- pc_write, sel 3, reg_target=32'h0040_0023 -> pc=32'h0040_0020, addr_err pulses one cycle.
- Assert rst_n low during REQ -> imem_req falls without waiting for a clock edge, all outputs take their reset values, and a subsequent ack has no effect.
- pc_write (sel 5) and fetch_start in the same IDLE cycle -> the fetch issues to imem_addr=32'h0040_0004. Then fetch at pc=32'hFFFF_FFFC -> pc wraps to 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage of the multi-cycle MIPS core.
// Holds the architectural PC, issues request/acknowledge fetches to
// instruction memory, latches the instruction register and loads redirect
// targets when the control FSM strobes pc_write.
//
// state | meaning
// IDLE  | waiting for fetch_start; pc_write redirects are accepted here
// REQ   | imem_req held high at a frozen imem_addr until imem_ack
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        pc_write,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] reg_target,
    input  logic [31:0] epc,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        busy,
    output logic        addr_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] src_val;
    logic        src_load;
    logic        src_check;
    logic [31:0] jump_target;

    // Jump target uses the current pc, which already points past the jump.
    assign jump_target = {pc_q[31:28], instr_q[25:0], 2'b00};

    // Select the redirect source; the adder result is trusted unchecked.
    always_comb begin
        src_val   = pc_q;
        src_load  = 1'b0;
        src_check = 1'b1;
        case (pc_sel)
            3'd0: begin
                src_val   = pc_plus4;
                src_load  = 1'b1;
                src_check = 1'b0;
            end
            3'd1: begin
                src_val  = branch_target;
                src_load = 1'b1;
            end
            3'd2: begin
                src_val  = jump_target;
                src_load = 1'b1;
            end
            3'd3: begin
                src_val  = reg_target;
                src_load = 1'b1;
            end
            3'd4: begin
                src_val  = epc;
                src_load = 1'b1;
            end
            3'd5: begin
                src_val  = EXC_VECTOR;
                src_load = 1'b1;
            end
            default: begin
                src_val  = pc_q;
                src_load = 1'b0;
            end
        endcase
    end

    // Next-state, PC and instruction register update.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        imem_addr_d   = imem_addr_q;
        instr_valid_d = 1'b0;
        addr_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pc_write && src_load) begin
                    if (src_check && (src_val[1:0] != 2'b00)) begin
                        pc_d       = {src_val[31:2], 2'b00};
                        addr_err_d = 1'b1;
                    end else begin
                        pc_d = src_val;
                    end
                end
                // A same-cycle redirect is fetched from, not the old pc.
                if (fetch_start) begin
                    state_d     = REQ;
                    imem_addr_d = pc_d;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    pc_d          = pc_plus4;
                    instr_valid_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            imem_addr_q   <= RESET_PC;
            instr_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_addr_q   <= imem_addr_d;
            instr_valid_q <= instr_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    // imem_req decodes straight from state so reset drops it immediately.
    assign imem_req    = (state_q == REQ);
    assign busy        = (state_q == REQ);
    assign pc          = pc_q;
    assign imem_addr   = imem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: redirect table, hand-written fetch sequences
// and a randomized run checked against a behavioural reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_start;
    logic        pc_write;
    logic [2:0]  pc_sel;
    logic [31:0] branch_target;
    logic [31:0] reg_target;
    logic [31:0] epc;
    logic [31:0] pc_plus4;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        busy;
    logic        addr_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    // External PC+4 adder, as in the datapath.
    assign pc_plus4 = pc + 32'd4;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_start  (fetch_start),
        .pc_write     (pc_write),
        .pc_sel       (pc_sel),
        .branch_target(branch_target),
        .reg_target   (reg_target),
        .epc          (epc),
        .pc_plus4     (pc_plus4),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .pc           (pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .busy         (busy),
        .addr_err     (addr_err)
    );

    // Reference model: architectural view of the fetch stage.
    bit          m_fetching;
    logic [31:0] m_pc, m_instr, m_addr;
    bit          m_valid, m_err;

    task automatic model_reset();
        m_fetching = 0;
        m_pc       = 32'h0040_0000;
        m_instr    = 32'h0;
        m_addr     = 32'h0040_0000;
        m_valid    = 0;
        m_err      = 0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        if (rst_n) begin
            m_valid = 0;
            m_err   = 0;
            if (m_fetching) begin
                if (imem_ack) begin
                    m_instr    = imem_rdata;
                    m_pc       = m_pc + 32'd4;
                    m_valid    = 1;
                    m_fetching = 0;
                end
            end else begin
                if (pc_write && pc_sel < 3'd6) begin
                    case (pc_sel)
                        3'd0:    t = m_pc + 32'd4;
                        3'd1:    t = branch_target;
                        3'd2:    t = (m_pc & 32'hF000_0000) + (m_instr % 32'h0400_0000) * 32'd4;
                        3'd3:    t = reg_target;
                        3'd4:    t = epc;
                        default: t = 32'h0040_0004;
                    endcase
                    if (pc_sel != 3'd0 && (t % 32'd4) != 32'd0) begin
                        m_err = 1;
                        t     = t - (t % 32'd4);
                    end
                    m_pc = t;
                end
                if (fetch_start) begin
                    m_fetching = 1;
                    m_addr     = m_pc;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic idle_inputs();
        fetch_start   = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = 3'd0;
        branch_target = 32'h0;
        reg_target    = 32'h0;
        epc           = 32'h0;
        imem_rdata    = 32'h0;
        imem_ack      = 1'b0;
    endtask

    // One clock: advance the model on the current inputs, then sample post-edge.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic        wr;
        logic [2:0]  sel;
        logic [31:0] br;
        logic [31:0] rt;
        logic [31:0] ep;
        logic [31:0] exp_pc;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 3'd1, 32'h1000_0000, 32'h0,          32'h0,          32'h1000_0000, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 32'h0,          32'h0,          32'h0,          32'h1000_0004, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 32'h0,          32'h0,          32'h0,          32'h1000_0000, 1'b0};
        vecs[3]  = '{1'b1, 3'd3, 32'h0,          32'h0040_0023, 32'h0,          32'h0040_0020, 1'b1};
        vecs[4]  = '{1'b1, 3'd4, 32'h0,          32'h0,          32'h3000_0010, 32'h3000_0010, 1'b0};
        vecs[5]  = '{1'b1, 3'd5, 32'h0,          32'h0,          32'h0,          32'h0040_0004, 1'b0};
        vecs[6]  = '{1'b1, 3'd6, 32'h2222_2220, 32'h3333_3330, 32'h4444_4440, 32'h0040_0004, 1'b0};
        vecs[7]  = '{1'b1, 3'd7, 32'h2222_2220, 32'h3333_3330, 32'h4444_4440, 32'h0040_0004, 1'b0};
        vecs[8]  = '{1'b1, 3'd1, 32'h1234_5679, 32'h0,          32'h0,          32'h1234_5678, 1'b1};
        vecs[9]  = '{1'b0, 3'd1, 32'h5555_5555, 32'h0,          32'h0,          32'h1234_5678, 1'b0};
        vecs[10] = '{1'b1, 3'd4, 32'h0,          32'h0,          32'h0000_0002, 32'h0000_0000, 1'b1};

        // Reset values
        idle_inputs();
        do_reset();
        check("rst_pc", pc, 32'h0040_0000);
        check("rst_instr", instr, 32'h0);
        check("rst_addr", imem_addr, 32'h0040_0000);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);

        // Zero-wait fetch
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("zw_req", 32'(imem_req), 32'd1);
        check("zw_busy", 32'(busy), 32'd1);
        check("zw_addr", imem_addr, 32'h0040_0000);
        check("zw_pc_hold", pc, 32'h0040_0000);
        imem_ack   = 1'b1;
        imem_rdata = 32'h8C08_0004;
        step();
        imem_ack = 1'b0;
        check("zw_instr", instr, 32'h8C08_0004);
        check("zw_pc", pc, 32'h0040_0004);
        check("zw_valid", 32'(instr_valid), 32'd1);
        check("zw_busy_done", 32'(busy), 32'd0);
        step();
        check("zw_valid_pulse", 32'(instr_valid), 32'd0);

        // Three wait cycles with ignored pc_write / fetch_start in REQ
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_write    = 1'b1;
            pc_sel      = (i == 1) ? 3'd3 : 3'd5;
            reg_target  = 32'h1111_1113;
            fetch_start = i[0];
            step();
            check("ws_addr", imem_addr, 32'h0040_0004);
            check("ws_pc", pc, 32'h0040_0004);
            check("ws_busy", 32'(busy), 32'd1);
            check("ws_err", 32'(addr_err), 32'd0);
        end
        idle_inputs();
        imem_ack   = 1'b1;
        imem_rdata = 32'h2108_0001;
        step();
        imem_ack = 1'b0;
        check("ws_instr", instr, 32'h2108_0001);
        check("ws_pc_ack", pc, 32'h0040_0008);
        check("ws_valid", 32'(instr_valid), 32'd1);
        step();
        check("ws_one_fetch", 32'(busy), 32'd0);
        check("ws_valid_pulse", 32'(instr_valid), 32'd0);
        check("ws_pc_final", pc, 32'h0040_0008);

        // Redirect table
        do_reset();
        foreach (vecs[k]) begin
            pc_write      = vecs[k].wr;
            pc_sel        = vecs[k].sel;
            branch_target = vecs[k].br;
            reg_target    = vecs[k].rt;
            epc           = vecs[k].ep;
            step();
            check($sformatf("tbl%0d_pc", k), pc, vecs[k].exp_pc);
            check($sformatf("tbl%0d_err", k), 32'(addr_err), 32'(vecs[k].exp_err));
            check($sformatf("tbl%0d_busy", k), 32'(busy), 32'd0);
        end
        idle_inputs();

        // Jump built from pc (post-fetch) and instr, with back-to-back fetch
        pc_write   = 1'b1;
        pc_sel     = 3'd3;
        reg_target = 32'h9000_000C;
        step();
        idle_inputs();
        check("j_pc_load", pc, 32'h9000_000C);
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = 32'h0800_0100;
        step();
        imem_ack = 1'b0;
        check("j_pc_fetch", pc, 32'h9000_0010);
        check("j_instr", instr, 32'h0800_0100);
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_addr", imem_addr, 32'h9000_0010);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0800_0100;
        step();
        imem_ack = 1'b0;
        check("b2b_pc", pc, 32'h9000_0014);
        pc_write = 1'b1;
        pc_sel   = 3'd2;
        step();
        pc_write = 1'b0;
        check("j_target", pc, 32'h9000_0400);
        check("j_err", 32'(addr_err), 32'd0);

        // Redirect and fetch in the same cycle, then PC wrap
        do_reset();
        pc_write    = 1'b1;
        pc_sel      = 3'd5;
        fetch_start = 1'b1;
        step();
        idle_inputs();
        check("same_addr", imem_addr, 32'h0040_0004);
        check("same_pc", pc, 32'h0040_0004);
        check("same_busy", 32'(busy), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0000;
        step();
        imem_ack = 1'b0;
        check("same_pc_ack", pc, 32'h0040_0008);
        pc_write   = 1'b1;
        pc_sel     = 3'd3;
        reg_target = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        check("wrap_load", pc, 32'hFFFF_FFFC);
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("wrap_pc", pc, 32'h0000_0000);

        // Asynchronous reset during REQ, then a late ack
        do_reset();
        pc_write    = 1'b1;
        pc_sel      = 3'd4;
        epc         = 32'h5555_0000;
        fetch_start = 1'b1;
        step();
        idle_inputs();
        check("ar_req_before", 32'(imem_req), 32'd1);
        check("ar_addr_before", imem_addr, 32'h5555_0000);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("ar_req_async", 32'(imem_req), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_pc", pc, 32'h0040_0000);
        check("ar_addr", imem_addr, 32'h0040_0000);
        check("ar_instr", instr, 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        idle_inputs();
        check("ar_late_instr", instr, 32'h0);
        check("ar_late_pc", pc, 32'h0040_0000);
        check("ar_late_valid", 32'(instr_valid), 32'd0);
        check("ar_late_busy", 32'(busy), 32'd0);

        // Randomized run against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            fetch_start   = ($urandom_range(0, 1) == 1);
            pc_write      = ($urandom_range(0, 1) == 1);
            pc_sel        = 3'($urandom_range(0, 7));
            branch_target = $urandom;
            reg_target    = $urandom;
            epc           = $urandom;
            imem_rdata    = $urandom;
            imem_ack      = ($urandom_range(0, 2) == 0);
            step();
            check("rnd_pc", pc, m_pc);
            check("rnd_instr", instr, m_instr);
            check("rnd_busy", 32'(busy), 32'(m_fetching));
            check("rnd_req", 32'(imem_req), 32'(m_fetching));
            if (m_fetching) check("rnd_addr", imem_addr, m_addr);
            check("rnd_valid", 32'(instr_valid), 32'(m_valid));
            check("rnd_err", 32'(addr_err), 32'(m_err));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
